// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a bank of common-anode
// seven-segment digits. A prescaler sets how long each digit is lit, a
// digit index walks the bank, and a shadow register holds the value on
// display so the source may change x freely between loads. All outputs
// are registered and active-low.
//
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zeros
// (every digit above digit 0 whose nibble and all higher nibbles are zero
// shows no segments). Left undefined, every digit shows its hex glyph.
module seven_seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   x,
  input  logic                  ld,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an
);

  // A one-digit bank still needs a one-bit index so the selection logic
  // stays uniform; it simply never leaves zero.
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] xs_q, xs_d;
  logic [DIGITS-1:0]   dps_q, dps_d;
  logic [6:0]          seg_q, seg_d;
  logic                dpo_q, dpo_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                pre_tc;
  logic [3:0]          cur_nib;
  logic                cur_dp;

  // Hex glyphs in {g,f,e,d,c,b,a} order, a lit segment is a 0.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] glyph;
    glyph = SEG_OFF;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = SEG_OFF;
    endcase
    return glyph;
  endfunction

  // Dwell prescaler and digit index; the index moves only on terminal count.
  always_comb begin
    pre_tc = (pre_q == PRE_LAST);
    pre_d  = pre_tc ? '0 : pre_q + 1'b1;
    idx_d  = idx_q;
    if (pre_tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow registers follow x/dp only on a load strobe.
  always_comb begin
    xs_d  = ld ? x  : xs_q;
    dps_d = ld ? dp : dps_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              higher_zero;
  logic              cur_blank;

  // Walk down from the top digit: a digit is a leading zero while it and
  // everything above it are zero.
  always_comb begin
    higher_zero = 1'b1;
    lead_zero   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero  = higher_zero & (xs_q[4*i +: 4] == 4'h0);
      lead_zero[i] = higher_zero;
    end
  end
`endif

  // Pick the nibble and decimal point belonging to the lit digit.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    cur_blank = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = xs_q[4*i +: 4];
        cur_dp  = dps_q[i];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = lead_zero[i] && (i != 0);
`endif
      end
    end
  end

  // Next output drive: glyph, decimal point and a one-hot-low anode that
  // is forced dark while the display is disabled.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    seg_d = cur_blank ? SEG_OFF : hex_glyph(cur_nib);
`else
    seg_d = hex_glyph(cur_nib);
`endif
    dpo_d = ~cur_dp;
    an_d  = '1;
    if (en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          an_d[i] = 1'b0;
        end
      end
    end
  end

  // State and output registers; reset wins over load and enable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
      idx_q <= '0;
      xs_q  <= '0;
      dps_q <= '0;
      seg_q <= SEG_OFF;
      dpo_q <= 1'b1;
      an_q  <= '1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      xs_q  <= xs_d;
      dps_q <= dps_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
      an_q  <= an_d;
    end
  end

  assign seg    = seg_q;
  assign dp_out = dpo_q;
  assign an     = an_q;

endmodule
